// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential divider.
package div_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ITERS         = WIDTH_DEFAULT;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StFix  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor holds between steps, so the shifted value fits in WIDTH+1 bits
    // and the trial's MSB is a reliable sign bit.
    always_comb begin
        shifted = {rem_i, q_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = trial[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multicycle DIV/DIVU sequencer: magnitude restoring divide, one quotient bit per clock,
// followed by a sign-fix cycle that writes the registered HI/LO results.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             by_zero
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               by_zero_q, by_zero_d;

    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic               sa_new;
    logic               sb_new;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .q_i       (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_quo)
    );

    assign sa_new = dividend[WIDTH-1] & is_signed;
    assign sb_new = divisor[WIDTH-1] & is_signed;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        by_zero_d = by_zero_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = sa_new;
                    sb_d    = sb_new;
                    quo_d   = sa_new ? -dividend : dividend;
                    dvs_d   = sb_new ? -divisor : divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    zero_d  = (divisor == '0);
                    state_d = (divisor == '0) ? StFix : StRun;
                end
            end
            StRun: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (zero_q) begin
                    // Quotient register still holds |A|; re-applying the sign restores A.
                    lo_d      = '0;
                    hi_d      = sa_q ? -quo_q : quo_q;
                    by_zero_d = 1'b1;
                end else begin
                    lo_d      = (sa_q ^ sb_q) ? -quo_q : quo_q;
                    hi_d      = sa_q ? -rem_q : rem_q;
                    by_zero_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            by_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            by_zero_q <= by_zero_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;
    assign by_zero = by_zero_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed corner cases plus randomized DIV/DIVU traffic.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        by_zero;

    div_seq_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .by_zero   (by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        bz;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   pushed = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic; SV '/' and '%' truncate toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit s);
        exp_t e;
        e.cyc = 0;
        if (b == 32'd0) begin
            e.lo = 32'd0;
            e.hi = a;
            e.bz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
            e.bz = 1'b0;
        end else if (s) begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
            e.bz = 1'b0;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
            e.bz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("lo_out", lo_out, e.lo);
                check("hi_out", hi_out, e.hi);
                check("by_zero", by_zero, e.bz);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // Issues one op the cycle after the previous one finished; optional stray start at N+inject.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input int inject);
        exp_t e;
        int   m;
        int   bc;
        bit   got;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        m         = cyc;
        e         = model(a, b, s);
        e.cyc     = m + 1 + ((b == 32'd0) ? 1 : 33);
        sb_q.push_back(e);
        pushed++;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_start", busy, 1);
        bc  = 1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (inject > 0 && cyc == m + inject) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom_range(1, 1000);
                is_signed = ~s;
            end
            if (done) got = 1'b1;
            else if (busy) bc++;
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: actual=no_done required=done (a=%0h b=%0h)", a, b);
        end
        check("busy_cycles", bc, (b == 32'd0) ? 1 : 33);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_hi"}, hi_out, 0);
        check({tag, "_lo"}, lo_out, 0);
        check({tag, "_by_zero"}, by_zero, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          r;
        int          m;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'h2, 1'b1, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_op(32'h1234_5678, 32'd0, 1'b1, 0);
        run_op(32'd10, 32'd3, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0);
        run_op(32'h8765_4321, 32'd0, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'd5, 32'd9, 1'b0, 0);

        // Stray start at N+5 while busy must be dropped.
        run_op(32'd1000, 32'd13, 1'b0, 5);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0)      rb = 32'd0;
            else if (r <= 3) rb = $urandom_range(1, 15);
            else if (r == 4) rb = 32'hFFFF_FFFF;
            else if (r == 5) rb = $urandom >> $urandom_range(0, 31);
            else             rb = $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        // Reset sampled at N+10, mid-RUN: op aborted, outputs cleared, no done.
        run_op(32'd100, 32'd7, 1'b0, 0);
        @(negedge clk);
        dividend  = 32'd500;
        divisor   = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        m         = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < m + 10) @(negedge clk);
        check("busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("midrun_reset");
        run_op(32'd9, 32'd4, 1'b0, 0);

        repeat (50) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        check("done_count", done_seen, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
